// File: rtl/ternary_neuron_acc.sv
// rtl/ternary_neuron_acc.sv - accumulate-and-threshold stage producing one ternary activation per neuron
//
// Purpose:
//   Accumulates (pos_cnt - neg_cnt) over the beats of one neuron.
//   On the in_last beat it compares the final sum against THR_POS/THR_NEG.
//   It then holds the ternary result until the consumer takes it.
//
// Optional feature:
//   TNEURON_ACC_SAT_EN - when defined, the accumulator clamps at the signed
//   ACC_W range instead of wrapping.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   pos_cnt, neg_cnt     unsigned popcounts of +1 and -1 weighted inputs
//   in_last              final beat of the current neuron
//   out_valid/out_ready  result handshake
//   act                  2'b01 = +1, 2'b11 = -1, 2'b00 = 0
//   sum                  final signed accumulated sum
//   beats                beats in the neuron (saturating)
//   beat_ovf             beat counter saturated during the neuron
module ternary_neuron_acc #(
  parameter int CNT_W   = 5,
  parameter int ACC_W   = 10,
  parameter int BEAT_W  = 5,
  parameter int THR_POS = 3,
  parameter int THR_NEG = -3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  pos_cnt,
  input  logic [CNT_W-1:0]  neg_cnt,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        act,
  output logic [ACC_W-1:0]  sum,
  output logic [BEAT_W-1:0] beats,
  output logic              beat_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] THR_POS_V = THR_POS[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] THR_NEG_V = THR_NEG[ACC_W-1:0];

  state_t state, state_next;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [BEAT_W-1:0] bcnt;
  logic [BEAT_W-1:0] bcnt_next;
  logic              ovf;
  logic              ovf_next;
  logic              bcnt_sat;
  logic              accept;
  logic [1:0]        act_next;

  // FSM next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef TNEURON_ACC_SAT_EN
  // One guard bit detects signed overflow; clamp toward the side it left from.
  logic [ACC_W:0] acc_wide;
  always_comb begin
    acc_wide = {acc[ACC_W-1], acc} + (ACC_W+1)'(pos_cnt) - (ACC_W+1)'(neg_cnt);
    if (acc_wide[ACC_W] != acc_wide[ACC_W-1])
      acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next = acc_wide[ACC_W-1:0];
  end
`else
  // Wrap-around: the guard bit would be discarded, so compute at ACC_W directly.
  assign acc_next = acc + ACC_W'(pos_cnt) - ACC_W'(neg_cnt);
`endif

  // Beat counter sticks at all-ones; any further beat marks overflow.
  assign bcnt_sat  = &bcnt;
  assign bcnt_next = bcnt_sat ? bcnt : bcnt + 1'b1;
  assign ovf_next  = ovf | bcnt_sat;

  always_comb begin
    act_next = 2'b00;
    if ($signed(acc_next) >= THR_POS_V)
      act_next = 2'b01;
    else if ($signed(acc_next) <= THR_NEG_V)
      act_next = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      bcnt     <= '0;
      ovf      <= 1'b0;
      act      <= 2'b00;
      sum      <= '0;
      beats    <= '0;
      beat_ovf <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (in_last) begin
          act      <= act_next;
          sum      <= acc_next;
          beats    <= bcnt_next;
          beat_ovf <= ovf_next;
          acc      <= '0;
          bcnt     <= '0;
          ovf      <= 1'b0;
        end else begin
          acc  <= acc_next;
          bcnt <= bcnt_next;
          ovf  <= ovf_next;
        end
      end
    end
  end

endmodule
